// File: rtl/cap_touch_pkg.sv
// Shared types and helpers for the capacitive pad scanner.
// Holds the scan state encoding and the event priority encoder.
package cap_touch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHARGE  = 2'd1,
    MEASURE = 2'd2,
    EVAL    = 2'd3
  } scan_state_t;

  localparam int MAX_PADS = 32;
  localparam int DEB_W    = 4;

  // Lowest set bit wins: walk from the top so later (lower) hits overwrite.
  function automatic logic [4:0] lowest_set_idx(input logic [MAX_PADS-1:0] vec);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = MAX_PADS - 1; i >= 0; i--) begin
      idx = vec[i] ? 5'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/cap_pad_channel.sv
// One pad: input synchronizer, per-scan discharge capture and debounced touch state.
// The published count only changes on measure_done, so readback is stable between scans.
module cap_pad_channel
  import cap_touch_pkg::*;
#(
  parameter int CNT_W    = 12,
  parameter int THRESH   = 400,
  parameter int DEBOUNCE = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sense,
  input  logic             clear,
  input  logic             measure,
  input  logic             measure_done,
  input  logic             evaluate,
  input  logic [CNT_W-1:0] meas_cnt,
  output logic             captured,
  output logic             sync_level,
  output logic [CNT_W-1:0] count,
  output logic             touched,
  output logic             rise
);

  logic [1:0]       sync_r;
  logic             captured_r;
  logic [CNT_W-1:0] work_r;
  logic [CNT_W-1:0] count_r;
  logic [DEB_W-1:0] deb_r;
  logic             touched_r;
  logic             raw_s;
  logic             flip_s;

  // Raw threshold decision and the scan on which the debounce run completes
  always_comb begin
    raw_s  = (count_r > CNT_W'(THRESH));
    flip_s = (raw_s != touched_r) && (deb_r == DEB_W'(DEBOUNCE - 1));
  end

  // Synchronizer, capture, count publication and debounce state
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_r     <= 2'b11;
      captured_r <= 1'b0;
      work_r     <= {CNT_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      deb_r      <= {DEB_W{1'b0}};
      touched_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], sense};
      if (clear) begin
        captured_r <= 1'b0;
        work_r     <= {CNT_W{1'b0}};
      end else if (measure && !captured_r && !sync_r[1]) begin
        captured_r <= 1'b1;
        work_r     <= meas_cnt;
      end
      // An uncaptured pad at exit is either capturing now or timing out; both take meas_cnt.
      if (measure_done) begin
        count_r <= captured_r ? work_r : meas_cnt;
      end
      if (evaluate) begin
        if (raw_s == touched_r) begin
          deb_r <= {DEB_W{1'b0}};
        end else if (flip_s) begin
          touched_r <= ~touched_r;
          deb_r     <= {DEB_W{1'b0}};
        end else begin
          deb_r <= deb_r + DEB_W'(1);
        end
      end
    end
  end

  assign captured   = captured_r;
  assign sync_level = sync_r[1];
  assign count      = count_r;
  assign touched    = touched_r;
  assign rise       = evaluate && flip_s && !touched_r;

endmodule

// File: rtl/cap_touch_scanner.sv
// Capacitive pad scanner: charge, time the discharge of every pad, debounce, report touches.
// Event outputs are registered at the end of EVAL and appear together with the updated touched.
module cap_touch_scanner
  import cap_touch_pkg::*;
#(
  parameter int N_PADS        = 9,
  parameter int CNT_W         = 12,
  parameter int CHARGE_CYCLES = 64,
  parameter int TIMEOUT       = 2047,
  parameter int THRESH        = 400,
  parameter int DEBOUNCE      = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [N_PADS-1:0]         sense_in,
  output logic                      charge_out,
  output logic [N_PADS-1:0]         touched,
  output logic [N_PADS-1:0]         new_touches,
  output logic                      touch_event,
  output logic [$clog2(N_PADS)-1:0] event_idx,
  output logic                      scan_done,
  input  logic [$clog2(N_PADS)-1:0] cnt_sel,
  output logic [CNT_W-1:0]          cnt_value
);

  localparam int IDX_W = $clog2(N_PADS);
  localparam int CC_W  = $clog2(CHARGE_CYCLES + 1);
  localparam logic [IDX_W:0] PAD_LIMIT = N_PADS[IDX_W:0];

  scan_state_t      state_r;
  logic [CC_W-1:0]  charge_cnt_r;
  logic [CNT_W-1:0] meas_cnt_r;

  logic             in_charge_s;
  logic             in_measure_s;
  logic             in_eval_s;
  logic             all_cap_s;
  logic             timeout_s;
  logic             meas_done_s;
  logic [N_PADS-1:0] captured_s;
  logic [N_PADS-1:0] sync_level_s;
  logic [N_PADS-1:0] rise_s;
  logic [CNT_W-1:0] pad_count_s [N_PADS];

  // Per-cycle control decode; a pad reading low this cycle counts as captured for exit purposes
  always_comb begin
    in_charge_s  = (state_r == CHARGE);
    in_measure_s = (state_r == MEASURE);
    in_eval_s    = (state_r == EVAL);
    all_cap_s    = &(captured_s | ~sync_level_s);
    timeout_s    = (meas_cnt_r == CNT_W'(TIMEOUT));
    meas_done_s  = in_measure_s && (all_cap_s || timeout_s);
  end

  for (genvar g = 0; g < N_PADS; g++) begin : g_pad
    cap_pad_channel #(
      .CNT_W   (CNT_W),
      .THRESH  (THRESH),
      .DEBOUNCE(DEBOUNCE)
    ) u_pad (
      .clock       (clock),
      .reset       (reset),
      .sense       (sense_in[g]),
      .clear       (in_charge_s),
      .measure     (in_measure_s),
      .measure_done(meas_done_s),
      .evaluate    (in_eval_s),
      .meas_cnt    (meas_cnt_r),
      .captured    (captured_s[g]),
      .sync_level  (sync_level_s[g]),
      .count       (pad_count_s[g]),
      .touched     (touched[g]),
      .rise        (rise_s[g])
    );
  end

  // Scan sequencer with registered charge drive and event outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      charge_cnt_r <= {CC_W{1'b0}};
      meas_cnt_r   <= {CNT_W{1'b0}};
      charge_out   <= 1'b0;
      scan_done    <= 1'b0;
      touch_event  <= 1'b0;
      new_touches  <= {N_PADS{1'b0}};
      event_idx    <= {IDX_W{1'b0}};
    end else begin
      scan_done   <= 1'b0;
      touch_event <= 1'b0;
      new_touches <= {N_PADS{1'b0}};
      event_idx   <= {IDX_W{1'b0}};
      case (state_r)
        IDLE: begin
          charge_out <= 1'b0;
          if (enable) begin
            state_r      <= CHARGE;
            charge_out   <= 1'b1;
            charge_cnt_r <= {CC_W{1'b0}};
          end
        end
        CHARGE: begin
          meas_cnt_r <= {CNT_W{1'b0}};
          if (charge_cnt_r == CC_W'(CHARGE_CYCLES - 1)) begin
            state_r    <= MEASURE;
            charge_out <= 1'b0;
          end else begin
            charge_cnt_r <= charge_cnt_r + CC_W'(1);
          end
        end
        MEASURE: begin
          if (meas_done_s) begin
            state_r <= EVAL;
          end else begin
            meas_cnt_r <= meas_cnt_r + CNT_W'(1);
          end
        end
        EVAL: begin
          scan_done   <= 1'b1;
          touch_event <= |rise_s;
          new_touches <= rise_s;
          event_idx   <= IDX_W'(lowest_set_idx(MAX_PADS'(rise_s)));
          // A scan always completes; enable only decides whether another one follows.
          if (enable) begin
            state_r      <= CHARGE;
            charge_out   <= 1'b1;
            charge_cnt_r <= {CC_W{1'b0}};
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r    <= IDLE;
          charge_out <= 1'b0;
        end
      endcase
    end
  end

  // Count readback; unused selector codes read zero
  always_comb begin
    if ({1'b0, cnt_sel} < PAD_LIMIT) begin
      cnt_value = pad_count_s[cnt_sel];
    end else begin
      cnt_value = {CNT_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_cap_touch_scanner.sv
// Randomized and directed checks of cap_touch_scanner against a per-scan behavioural model.
module tb_cap_touch_scanner;

  localparam int N  = 9;
  localparam int CW = 12;
  localparam int CC = 8;
  localparam int TO = 255;
  localparam int TH = 40;
  localparam int DB = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [N-1:0]  sense_in;
  logic          charge_out;
  logic [N-1:0]  touched;
  logic [N-1:0]  new_touches;
  logic          touch_event;
  logic [3:0]    event_idx;
  logic          scan_done;
  logic [3:0]    cnt_sel;
  logic [CW-1:0] cnt_value;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: pad drop cycles for the next scan, touch state, debounce runs, results
  int           drop [N];
  bit           finger [N];
  bit           m_touched [N];
  int           m_streak [N];
  int           m_prev_count [N];
  bit           m_pending;
  logic [N-1:0] m_new;
  bit           m_event;
  int           m_idx;

  cap_touch_scanner #(
    .N_PADS(N), .CNT_W(CW), .CHARGE_CYCLES(CC),
    .TIMEOUT(TO), .THRESH(TH), .DEBOUNCE(DB)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .sense_in(sense_in),
    .charge_out(charge_out), .touched(touched), .new_touches(new_touches),
    .touch_event(touch_event), .event_idx(event_idx), .scan_done(scan_done),
    .cnt_sel(cnt_sel), .cnt_value(cnt_value)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_touched[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_touched[i] = 1'b0;
      m_streak[i] = 0;
      m_prev_count[i] = 0;
    end
    m_pending = 1'b0;
  endtask

  // Called at the negedge of the cycle following EVAL
  task automatic check_results();
    check_val("scan_done", 32'(scan_done), 32'd1);
    check_val("touched", 32'(touched), 32'(model_vec()));
    check_val("touch_event", 32'(touch_event), 32'(m_event));
    if (m_event) begin
      check_val("new_touches", 32'(new_touches), 32'(m_new));
      check_val("event_idx", 32'(event_idx), 32'(m_idx));
    end
    m_pending = 1'b0;
  endtask

  // Entered at posedge+1 of the first CHARGE cycle; returns at posedge+1 after EVAL
  task automatic run_scan(input int dis_c);
    int  cnt [N];
    int  m;
    bit  raw;
    m = 0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = (drop[i] + 2 > TO) ? TO : drop[i] + 2;
      if (cnt[i] + 1 > m) m = cnt[i] + 1;
    end
    sense_in = {N{1'b1}};
    for (int c = 0; c <= CC + m; c++) begin
      for (int i = 0; i < N; i++) begin
        if (c == CC + drop[i]) sense_in[i] = 1'b0;
      end
      if (c == dis_c) enable = 1'b0;
      if (c < N) cnt_sel = 4'(c);
      @(negedge clock);
      if (c == 0) begin
        if (m_pending) check_results();
        else check_val("idle_pulse", 32'({scan_done, touch_event}), 32'd0);
        check_val("charge_start", 32'(charge_out), 32'd1);
      end else begin
        check_val("scan_cycle", 32'({charge_out, scan_done, touch_event, touched}),
                  32'({c < CC, 2'b00, model_vec()}));
      end
      if (c < N) check_val("cnt_hold", 32'(cnt_value), 32'(m_prev_count[c]));
      @(posedge clock);
      #1;
    end
    m_new = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      m_prev_count[i] = cnt[i];
      raw = (cnt[i] > TH);
      if (raw == m_touched[i]) begin
        m_streak[i] = 0;
      end else begin
        m_streak[i]++;
        if (m_streak[i] == DB) begin
          if (!m_touched[i]) m_new[i] = 1'b1;
          m_touched[i] = raw;
          m_streak[i] = 0;
        end
      end
    end
    m_event = |m_new;
    m_idx = 0;
    for (int i = N - 1; i >= 0; i--) if (m_new[i]) m_idx = i;
    m_pending = 1'b1;
  endtask

  // After a scan that ended with enable low: results, then the FSM must sit in IDLE
  task automatic idle_check(input int n);
    @(negedge clock);
    check_results();
    check_val("idle_charge", 32'(charge_out), 32'd0);
    @(posedge clock);
    #1;
    for (int i = 0; i < n; i++) begin
      cnt_sel = 4'(i % N);
      @(negedge clock);
      check_val("idle_cycle", 32'({charge_out, scan_done, touch_event, touched}),
                32'({3'b000, model_vec()}));
      check_val("idle_cnt", 32'(cnt_value), 32'(m_prev_count[i % N]));
      @(posedge clock);
      #1;
    end
  endtask

  task automatic start_scan();
    enable = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic set_drops(input int others, input int p_a, input int k_a, input int p_b, input int k_b);
    for (int i = 0; i < N; i++) drop[i] = others;
    if (p_a >= 0) drop[p_a] = k_a;
    if (p_b >= 0) drop[p_b] = k_b;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    sense_in = {N{1'b1}};
    cnt_sel = 4'd0;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_val("reset_out", 32'({charge_out, scan_done, touch_event, touched, new_touches, event_idx}), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // All pads drop at MEASURE cycle 5
    set_drops(5, -1, 0, -1, 0);
    start_scan();
    run_scan(-1);

    // Glitch: pad 4 touched for two scans only
    set_drops(10, 4, 60, -1, 0);
    repeat (2) run_scan(-1);
    set_drops(10, -1, 0, -1, 0);
    repeat (2) run_scan(-1);

    // Debounced touch on pad 4
    set_drops(10, 4, 60, -1, 0);
    repeat (3) run_scan(-1);

    // Pads 2 and 7 never discharge: timeout, simultaneous event
    set_drops(10, 4, 60, 2, 1000);
    drop[7] = 1000;
    repeat (3) run_scan(-1);

    // Release pad 2; drop enable during MEASURE of the final scan
    drop[2] = 10;
    repeat (2) run_scan(-1);
    run_scan(CC + 5);
    idle_check(6);

    // Reset during CHARGE
    start_scan();
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    @(negedge clock);
    check_val("pre_reset_charge", 32'(charge_out), 32'd1);
    @(posedge clock);
    #1;
    enable = 1'b0;
    sense_in = {N{1'b1}};
    cnt_sel = 4'd4;
    model_reset();
    @(negedge clock);
    check_val("mid_reset_out", 32'({charge_out, scan_done, touch_event, touched}), 32'd0);
    check_val("mid_reset_cnt", 32'(cnt_value), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Randomized scans with per-pad finger state
    for (int i = 0; i < N; i++) finger[i] = 1'b0;
    start_scan();
    for (int s = 0; s < 40; s++) begin
      int r;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) finger[i] = !finger[i];
        r = int'($urandom_range(0, 19));
        if (r == 0) drop[i] = 1000;
        else if (r == 1) drop[i] = -2 + int'($urandom_range(0, 1));
        else if (finger[i]) drop[i] = int'($urandom_range(39, 90));
        else drop[i] = int'($urandom_range(0, 38));
      end
      run_scan((s == 39) ? int'($urandom_range(1, CC + 3)) : -1);
    end
    idle_check(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cap_touch_scanner.md
# cap_touch_scanner

Parametrised capacitive-pad scanner for the whack-a-mole board: drives the shared charge line, times each pad's discharge, thresholds and debounces per pad, and reports a stable touched bitmap plus one-cycle new-touch events to the processor's memory-mapped I/O. It replaces fixed 9-pad sampling with configurable pad count, count width, threshold and debounce depth.

## Interface
Parameters:
- N_PADS, 9: number of capacitive pads.
- CNT_W, 12: discharge counter width.
- CHARGE_CYCLES, 64: cycles `charge_out` is held high per scan.
- TIMEOUT, 2047: maximum measure count. Must be < 2^CNT_W.
- THRESH, 400: a count strictly greater than THRESH is a raw touch.
- DEBOUNCE, 3: consecutive agreeing scans required to change `touched`. Range 1..15.

Ports:
- clock, in, 1: single clock.
- reset, in, 1: synchronous, active-high.
- enable, in, 1: start or continue scanning.
- sense_in, in, N_PADS: asynchronous pad comparator inputs.
- charge_out, out, 1: shared charge drive.
- touched, out, N_PADS: debounced touch state.
- new_touches, out, N_PADS: pads that went 0->1 this scan. Valid while `touch_event` is high.
- touch_event, out, 1: one-cycle pulse.
- event_idx, out, $clog2(N_PADS): lowest-index bit of `new_touches`.
- scan_done, out, 1: one-cycle pulse at the end of every scan.
- cnt_sel, in, $clog2(N_PADS): pad selector for count readback.
- cnt_value, out, CNT_W: last completed count of pad `cnt_sel`. Combinational mux.

## Operation
- The FSM states are IDLE, CHARGE, MEASURE and EVAL.
- IDLE:
  - `charge_out` = 0.
  - Moves to CHARGE when `enable` = 1.
- CHARGE:
  - `charge_out` = 1 for exactly CHARGE_CYCLES cycles, then moves to MEASURE.
  - The measure counter clears to 0 and all capture flags clear.
- MEASURE:
  - `charge_out` = 0. The counter increments each cycle, starting at 0 in the first MEASURE cycle.
  - `sense_in` passes through a 2-flop synchronizer.
  - A pad is captured in the first MEASURE cycle its synchronized input reads 0. Its count is the counter value in that cycle, and it is captured once per scan.
  - When the counter equals TIMEOUT, every uncaptured pad takes TIMEOUT.
  - Exit to EVAL when all pads are captured or the counter reaches TIMEOUT.
- EVAL (single cycle):
  - raw[i] = count[i] > THRESH.
  - Per-pad debounce counter:
    - If raw[i] == touched[i], the counter clears.
    - Otherwise it increments. On reaching DEBOUNCE, touched[i] toggles and the counter clears.
  - `touched` updates at the end of EVAL.
  - `scan_done` = 1.
  - `touch_event` = 1 if any bit went 0->1, with `new_touches` and `event_idx` valid in the same cycle.
  - Next state is CHARGE if `enable` = 1, else IDLE.
- Disabling `enable` mid-scan does not stop the scan: it completes and then returns to IDLE.
- Several pads becoming touched in the same scan produce one event: all bits set in `new_touches`, `event_idx` = lowest index.
- A 1->0 transition (release) generates no event.

## Timing
- Reset values:
  - state IDLE.
  - `charge_out`, `touched`, `new_touches`, `touch_event`, `event_idx`, `scan_done` all 0.
  - All stored counts and debounce counters 0.
  - Synchronizer flops 1.
- Reset mid-scan takes effect at the next edge: IDLE, outputs as above.
- Scan period = 1 (IDLE, first scan only) + CHARGE_CYCLES + M + 1, where M = MEASURE cycles:
  - M = (last capture count + 1), or TIMEOUT + 1 on timeout.
  - Back-to-back scans skip IDLE.
- Synchronizer latency is 2 cycles. A pad driven low at the edge starting MEASURE cycle k captures count k+2.
- A pad already low on MEASURE cycle 0 (synchronized) gets count 0.
- `touched` changes at the earliest DEBOUNCE scans after the raw state flips.
- `cnt_value` updates at the end of MEASURE and holds until the next scan's MEASURE completes.

## Structure
- Package `cap_touch_pkg`: state enum `scan_state_t`, and helper function for `event_idx` priority encode.
- Sub-module `cap_pad_channel`, generated N_PADS times. It contains the synchronizer, the capture flag/count register and the debounce counter/`touched` bit.
- The top holds the FSM, the measure counter, the all-captured reduction, the event encoder and the readback mux.

## Test plan
All scenarios use N_PADS=9, CHARGE_CYCLES=8, TIMEOUT=255, THRESH=40, DEBOUNCE=3.
- Reset and enable:
  - Hold reset for 3 cycles; all outputs are 0.
  - Raise `enable`: `charge_out` is high for exactly 8 cycles.
  - With all pads dropping at MEASURE cycle 5, counts read 7 and `scan_done` pulses once.
- Touch debounce:
  - Pad 4 drops at k=60 (count 62), all others at k=10 (count 12).
  - Scans 1-2: `touched` = 0.
  - Scan 3 EVAL: `touched` = 9'b000010000, `touch_event` = 1, `event_idx` = 4.
- Glitch rejection: pad 4 is touched for 2 scans, then untouched. `touched` never rises and no event occurs.
- Simultaneous touches and timeout:
  - Pads 2 and 7 never drop. Timeout gives count 255, M = 256.
  - After 3 scans, one event with `new_touches` = 9'b010000100 and `event_idx` = 2.
- Release and mid-scan control:
  - Release pad 2: `touched[2]` clears after 3 scans with no event.
  - Deassert `enable` during MEASURE: the scan completes, then the FSM goes to IDLE.
  - Assert reset during CHARGE: `charge_out` = 0 next cycle and `touched` clears.
